servo_ramp_scheduler: RTL and testbench

SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

---
 rtl/servo_ramp_scheduler_if.sv | 22 ++
 rtl/servo_ramp_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_servo_ramp_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_ramp_scheduler_if.sv
// Command handshake bundle for servo_ramp_scheduler.
// Master drives cmd_valid/cmd_chan/cmd_pos, slave returns cmd_ready.
interface servo_ramp_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_chan;
  logic [7:0] cmd_pos;

  modport master (
    output cmd_valid,
    output cmd_chan,
    output cmd_pos,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_chan,
    input  cmd_pos,
    output cmd_ready
  );
endinterface

// File: rtl/servo_ramp_scheduler.sv
// Four-channel servo position ramp scheduler, one channel per sweep cycle.
// Optional macro SERVO_TIMEOUT_EN disables channels left without commands.
module servo_ramp_scheduler #(
  parameter int unsigned FRAME_CYCLES   = 1500000,
  parameter int unsigned STEP           = 4,
  parameter int unsigned TIMEOUT_FRAMES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  servo_ramp_scheduler_if.slave cmd,
  output logic [31:0]           pos_out,
  output logic [3:0]            drv_enable,
  output logic [3:0]            at_target,
  output logic                  frame_tick
);

  localparam int unsigned CW =
    (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  // A step of 255 already spans the full range, so the
  // 9-bit ramp sums below can never overflow.
  localparam logic [8:0] STEP9 =
    (STEP > 255) ? 9'd255 : 9'(STEP);

  // UPDn carries the channel number in its low bits.
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] UPD0 = 3'd4;
  localparam logic [2:0] UPD1 = 3'd5;
  localparam logic [2:0] UPD2 = 3'd6;
  localparam logic [2:0] UPD3 = 3'd7;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [CW-1:0]   frame_cnt;
  logic            ready_q;
  logic            accept;
  logic [3:0][7:0] cur;
  logic [3:0][7:0] tgt;
  logic [1:0]      upd_ch;
  logic            upd_go;
  logic [7:0]      cur_sel;
  logic [7:0]      tgt_sel;
  logic [8:0]      c9;
  logic [8:0]      t9;
  logic [8:0]      up9;
  logic [8:0]      dn9;
  logic [7:0]      ramp_nxt;

  assign accept        = cmd.cmd_valid && ready_q;
  assign cmd.cmd_ready = ready_q;
  assign frame_tick    = (frame_cnt == LAST);
  assign pos_out       = cur;
  assign upd_ch        = state[1:0];
  assign upd_go        = state[2];

  // Free-running frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_cnt == LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Sweep sequencing: one frame tick walks UPD0..UPD3 once.
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = frame_tick ? UPD0 : IDLE;
      UPD0:    state_nxt = UPD1;
      UPD1:    state_nxt = UPD2;
      UPD2:    state_nxt = UPD3;
      UPD3:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; ready is registered so it stays low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
    end
  end

  // Next position for the channel being swept, clamped at target.
  always_comb begin
    cur_sel  = cur[upd_ch];
    tgt_sel  = tgt[upd_ch];
    c9       = {1'b0, cur_sel};
    t9       = {1'b0, tgt_sel};
    up9      = c9 + STEP9;
    dn9      = c9 - STEP9;
    ramp_nxt = cur_sel;
    unique case (1'b1)
      c9 < t9:
        ramp_nxt = (STEP9 == 9'd0 || up9 >= t9)
                   ? tgt_sel : up9[7:0];
      c9 > t9:
        ramp_nxt = (STEP9 == 9'd0 || c9 < STEP9 || dn9 <= t9)
                   ? tgt_sel : dn9[7:0];
      default:
        ramp_nxt = cur_sel;
    endcase
  end

  // Targets load from commands; positions move during the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= {4{8'd128}};
      tgt <= {4{8'd128}};
    end else begin
      if (accept) begin
        tgt[cmd.cmd_chan] <= cmd.cmd_pos;
      end
      if (upd_go && drv_enable[upd_ch]) begin
        cur[upd_ch] <= ramp_nxt;
      end
    end
  end

  // Per-channel arrival flags.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      at_target[n] = (cur[n] == tgt[n]);
    end
  end

`ifdef SERVO_TIMEOUT_EN
  localparam int unsigned TW =
    ($clog2(TIMEOUT_FRAMES + 1) > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_FRAMES);

  logic [3:0][TW-1:0] idle_frames;

  // Frames since the last command, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_frames <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (accept && cmd.cmd_chan == 2'(n)) begin
          idle_frames[n] <= '0;
        end else if (frame_tick && idle_frames[n] != TLIM) begin
          idle_frames[n] <= idle_frames[n] + 1'b1;
        end
      end
    end
  end

  // A command enables its channel; silence past the limit disables it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_enable <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (accept && cmd.cmd_chan == 2'(n)) begin
          drv_enable[n] <= 1'b1;
        end else if (idle_frames[n] == TLIM) begin
          drv_enable[n] <= 1'b0;
        end
      end
    end
  end
`else
  // A command enables its channel until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_enable <= 4'b0000;
    end else if (accept) begin
      drv_enable[cmd.cmd_chan] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Directed bench for servo_ramp_scheduler: STEP=4 and STEP=200 instances.
// Scoreboard queue holds per-frame predictions from a behavioural model.
module tb_servo_ramp_scheduler;

  localparam int FC = 100;
  localparam int TO = 3;
  localparam int LIM = 150;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  servo_ramp_scheduler_if ifa ();
  servo_ramp_scheduler_if ifc ();

  logic [31:0] pos_a, pos_c;
  logic [3:0]  en_a, en_c, at_a, at_c;
  logic        tick_a, tick_c;

  servo_ramp_scheduler #(
    .FRAME_CYCLES(FC), .STEP(4), .TIMEOUT_FRAMES(TO)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(ifa),
    .pos_out(pos_a), .drv_enable(en_a),
    .at_target(at_a), .frame_tick(tick_a)
  );

  servo_ramp_scheduler #(
    .FRAME_CYCLES(FC), .STEP(200), .TIMEOUT_FRAMES(TO)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .cmd(ifc),
    .pos_out(pos_c), .drv_enable(en_c),
    .at_target(at_c), .frame_tick(tick_c)
  );

  typedef struct {
    logic [31:0] pos;
    logic [3:0]  en;
    logic [3:0]  at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mcur[2][4];
  int   mtgt[2][4];
  int   mto[2][4];
  bit   men[2][4];
  int   steps[2] = '{4, 200};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound(input string tag, input int n);
    checks++;
    assert (n < LIM) else begin
      errors++;
      $error("FAIL %s observed=%0d cycles expected=<%0d", tag, n, LIM);
    end
  endtask

  function automatic int ramp(input int c, input int t, input int s);
    if (s == 0) return t;
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 4; n++) begin
        mcur[i][n] = 128;
        mtgt[i][n] = 128;
        mto[i][n]  = 0;
        men[i][n]  = 1'b0;
      end
    end
    exp_q.delete();
  endfunction

  function automatic void model_cmd(input int i, input int ch, input int p);
    mtgt[i][ch] = p;
    men[i][ch]  = 1'b1;
    mto[i][ch]  = 0;
  endfunction

  function automatic void model_frame(input int si, input int sc);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 4; n++) begin
`ifdef SERVO_TIMEOUT_EN
        if (!(i == si && n == sc)) begin
          if (mto[i][n] < TO) mto[i][n]++;
          if (mto[i][n] >= TO) men[i][n] = 1'b0;
        end
`endif
        if (men[i][n]) mcur[i][n] = ramp(mcur[i][n], mtgt[i][n], steps[i]);
      end
      for (int n = 0; n < 4; n++) begin
        e.pos[8*n +: 8] = 8'(mcur[i][n]);
        e.en[n]         = men[i][n];
        e.at[n]         = (mcur[i][n] == mtgt[i][n]);
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic drive(input int i, input logic v, input logic [1:0] ch,
                       input logic [7:0] p);
    if (i == 0) begin
      ifa.cmd_valid = v; ifa.cmd_chan = ch; ifa.cmd_pos = p;
    end else begin
      ifc.cmd_valid = v; ifc.cmd_chan = ch; ifc.cmd_pos = p;
    end
  endtask

  task automatic send(input int i, input logic [1:0] ch, input logic [7:0] p);
    int n = 0;
    @(negedge clk);
    drive(i, 1'b1, ch, p);
    while ((i == 0 ? ifa.cmd_ready : ifc.cmd_ready) !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    bound("send_wait", n);
    @(posedge clk);
    #1;
    drive(i, 1'b0, ch, p);
    model_cmd(i, ch, p);
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (tick_a !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    bound("tick_wait", n);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (exp_q.size() == 0) begin
        bound({tag, "_empty_q"}, LIM);
      end else begin
        e = exp_q.pop_front();
        chk({tag, i == 0 ? "_pos_a" : "_pos_c"}, i == 0 ? pos_a : pos_c, e.pos);
        chk({tag, i == 0 ? "_en_a" : "_en_c"},
            32'(i == 0 ? en_a : en_c), 32'(e.en));
        chk({tag, i == 0 ? "_at_a" : "_at_c"},
            32'(i == 0 ? at_a : at_c), 32'(e.at));
      end
    end
  endtask

  task automatic frame(input string tag);
    wait_tick();
    chk({tag, "_tick_c"}, 32'(tick_c), 32'(1));
    model_frame(-1, -1);
    repeat (5) @(negedge clk);
    compare(tag);
  endtask

  initial begin
    drive(0, 1'b0, 2'd0, 8'd0);
    drive(1, 1'b0, 2'd0, 8'd0);
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pos_a", pos_a, 32'h8080_8080);
    chk("rst_pos_c", pos_c, 32'h8080_8080);
    chk("rst_en", 32'(en_a), 32'h0);
    chk("rst_at", 32'(at_a), 32'hF);
    chk("rst_ready", 32'(ifa.cmd_ready), 32'h0);
    chk("rst_tick", 32'(tick_a), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ifa.cmd_ready), 32'h1);
    chk("rel_pos", pos_a, 32'h8080_8080);
    chk("rel_at", 32'(at_a), 32'hF);
    chk("rel_en", 32'(en_a), 32'h0);

    for (int k = 0; k < 4; k++) begin
      send(0, 2'd1, 8'h90);
      if (k == 0) send(1, 2'd0, 8'hFF);
      if (k == 1) send(1, 2'd0, 8'h00);
      frame("ramp");
      chk("ramp_ch1", 32'(pos_a[15:8]), 32'(8'h84 + 4 * k));
      if (k == 0) chk("clamp_hi", 32'(pos_c[7:0]), 32'hFF);
      if (k == 2) chk("clamp_lo", 32'(pos_c[7:0]), 32'h00);
    end
    chk("ramp_at1", 32'(at_a[1]), 32'h1);
    chk("ramp_others", {pos_a[31:16], pos_a[7:0]}, 32'h80_8080);

    wait_tick();
    drive(0, 1'b1, 2'd3, 8'h70);
    model_cmd(0, 3, 8'h70);
    model_frame(0, 3);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 2'd3, 8'h70);
    repeat (5) @(negedge clk);
    compare("coinc");
    chk("coinc_ch3", 32'(pos_a[31:24]), 32'h7C);

    wait_tick();
    model_frame(-1, -1);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 2'd3, 8'h60);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("coll_busy", 32'(ifa.cmd_ready), 32'h0);
    end
    @(negedge clk);
    chk("coll_ready", 32'(ifa.cmd_ready), 32'h1);
    compare("coll");
    @(posedge clk);
    #1;
    drive(0, 1'b0, 2'd3, 8'h60);
    model_cmd(0, 3, 8'h60);
    @(negedge clk);
    chk("coll_tgt", 32'(at_a[3]), 32'h0);

    send(0, 2'd2, 8'hC0);
    frame("to1");
    frame("to2");
    frame("to3");
`ifdef SERVO_TIMEOUT_EN
    chk("to_en2", 32'(en_a[2]), 32'h0);
`else
    chk("to_en2", 32'(en_a[2]), 32'h1);
`endif
    frame("to4");
`ifdef SERVO_TIMEOUT_EN
    chk("to_pos2", 32'(pos_a[23:16]), 32'h88);
`else
    chk("to_pos2", 32'(pos_a[23:16]), 32'h90);
`endif

    wait_tick();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_pos_a", pos_a, 32'h8080_8080);
    chk("mrst_pos_c", pos_c, 32'h8080_8080);
    chk("mrst_en", 32'(en_a), 32'h0);
    chk("mrst_at", 32'(at_a), 32'hF);
    chk("mrst_ready", 32'(ifa.cmd_ready), 32'h0);
    chk("mrst_tick", 32'(tick_a), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel_ready", 32'(ifa.cmd_ready), 32'h1);
    send(0, 2'd0, 8'h84);
    frame("restart");
    chk("restart_ch0", 32'(pos_a[7:0]), 32'h84);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
